cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
Parametrised successor to the fixed-width control block. It generates the CPU control word from a step counter and the current opcode. Fetch steps come from built-in constants; execute steps come from an external asynchronous microcode ROM. Adds over the fixed block: variable-length instructions via a ROM end flag, pipeline stall, halt opcode detection and a retired-instruction counter. Sits between the instruction register, the microcode ROM and every control-signal consumer (PC, registers, ALU, bus drivers).

Parameters:
OPCODE_W, 4, opcode width from IR
CTRL_W, 15, control word width
MAX_STEPS, 8, T-states per instruction including fetch (>= 3)
STEP_W, $clog2(MAX_STEPS), step counter width (derived)
FETCH_CTRL_0, 15'h0000, control word for fetch step 0 (PC out, MAR in)
FETCH_CTRL_1, 15'h0000, control word for fetch step 1 (RAM out, IR in, PC inc)
HALT_OPCODE, 4'hF, opcode that halts the sequencer
CNT_W, 16, retired counter width

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
opcode  input  OPCODE_W  current IR opcode; valid from step 2 onward
stall  input  1  freeze sequencer and suppress control word
ucode_addr  output  OPCODE_W+STEP_W  ROM address {opcode, step}
ucode_word  input  CTRL_W+1  ROM data: [CTRL_W] = end flag, [CTRL_W-1:0] = control word
ctrl_out  output  CTRL_W  control word to datapath
step  output  STEP_W  current T-state
halted  output  1  high in HALTED state
instr_done  output  1  high during the final step of a completed instruction
retired  output  CNT_W  count of completed non-halt instructions

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- States: IDLE, FETCH, EXEC, HALTED.
- Reset state: state=IDLE, step=0, retired=0, ctrl_out=0, halted=0, instr_done=0.
- IDLE: ctrl_out=0. Moves to FETCH step 0 on the next edge with stall low.
- FETCH: ctrl_out=FETCH_CTRL_0 at step 0 and FETCH_CTRL_1 at step 1, independent of the ROM.
  - Step 0 -> step 1 -> EXEC step 2, one step per unstalled edge.
  - The IR loads on the edge that leaves step 1.
- EXEC: ctrl_out = ucode_word[CTRL_W-1:0], combinational from ROM.
  - Step 2 with opcode==HALT_OPCODE: ctrl_out=0; next edge -> HALTED. No instr_done, retired unchanged.
  - Otherwise the step is last if ucode_word[CTRL_W]==1 or step==MAX_STEPS-1 (forced end).
  - Last step: instr_done=1; next edge -> FETCH step 0; retired+1, wrapping at 2^CNT_W.
  - Not last: step+1.
- HALTED: ctrl_out=0, halted=1, step holds. Only reset exits.
- ucode_addr = {opcode, step} at all times; the ROM contents during FETCH/IDLE/HALTED are don't-care.
- Stall (sampled per edge, state frozen on any edge where stall=1):
  - Forces ctrl_out=0 and instr_done=0 combinationally in all states.
  - A stalled last step re-evaluates and pulses instr_done once when stall drops. Retired increments exactly once.
  - No effect in HALTED beyond holding ctrl_out=0.
- Reset mid-instruction: immediate return to the reset state with outputs at reset values; the next instruction starts from FETCH.
- All registered state is updated on the clk rising edge only; no latches.

Test Plan:
- Reset release, stall=0 -> cycle 0 IDLE ctrl_out=0; cycle 1 FETCH_CTRL_0 with step=0; cycle 2 FETCH_CTRL_1; cycle 3 step=2 with ucode_addr={opcode,3'd2}.
- opcode=4'h2, ROM end flag at step 4 -> steps 2,3,4 drive ROM words; instr_done high only at step 4; retired 0->1; next cycle step=0.
- ROM end flag never set, MAX_STEPS=8 -> forced end at step 7, instr_done at step 7, return to fetch.
- stall=1 for 3 cycles at step 3 -> step holds 3, ctrl_out=0 for those 3 cycles; resumes at step 3 with the ROM word; retired increments exactly once.
- opcode=4'hF -> step 2 ctrl_out=0; halted=1 the next cycle and stays for 20 cycles; retired unchanged; rst_n low asynchronously clears halted without a clock edge.
- retired preset near wrap (CNT_W=4, 16 instructions) -> retired 15->0; rst_n pulsed at step 3 -> outputs return to reset values immediately.

Source files
------------

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer
// Generates the CPU control word from a T-state counter and the current
// opcode. Fetch steps use built-in constant words; execute steps read an
// external asynchronous microcode ROM addressed by {opcode, step}. Supports
// variable-length instructions (ROM end flag), pipeline stall, a halt opcode
// and a retired-instruction counter.

module cpu_control_sequencer #(
  parameter int                    OPCODE_W     = 4,
  parameter int                    CTRL_W       = 15,
  parameter int                    MAX_STEPS    = 8,
  parameter int                    STEP_W       = $clog2(MAX_STEPS),
  parameter logic [CTRL_W-1:0]     FETCH_CTRL_0 = 15'h0000,
  parameter logic [CTRL_W-1:0]     FETCH_CTRL_1 = 15'h0000,
  parameter logic [OPCODE_W-1:0]   HALT_OPCODE  = 4'hF,
  parameter int                    CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [OPCODE_W-1:0]        opcode,
  input  logic                       stall,
  output logic [OPCODE_W+STEP_W-1:0] ucode_addr,
  input  logic [CTRL_W:0]            ucode_word,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [STEP_W-1:0]          step,
  output logic                       halted,
  output logic                       instr_done,
  output logic [CNT_W-1:0]           retired
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [STEP_W-1:0] STEP_ZERO = '0;
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_TWO  = STEP_W'(2);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  logic [1:0]        state_q;
  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  retired_q;

  logic rom_end;
  logic halt_step;
  logic last_step;

  // The halt opcode is only recognised on the first execute step, before
  // any ROM word for it is allowed to reach the datapath.
  assign rom_end   = ucode_word[CTRL_W];
  assign halt_step = (state_q == S_EXEC) && (step_q == STEP_TWO) &&
                     (opcode == HALT_OPCODE);
  assign last_step = (state_q == S_EXEC) && !halt_step &&
                     (rom_end || (step_q == STEP_LAST));

  // State, step counter and retired counter; every edge with stall high
  // leaves all three untouched so a stalled last step retires exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      step_q    <= STEP_ZERO;
      retired_q <= '0;
    end else if (!stall) begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          step_q  <= STEP_ZERO;
        end
        S_FETCH: begin
          if (step_q == STEP_ZERO) begin
            step_q <= STEP_ONE;
          end else begin
            state_q <= S_EXEC;
            step_q  <= STEP_TWO;
          end
        end
        S_EXEC: begin
          if (halt_step) begin
            state_q <= S_HALTED;
          end else if (last_step) begin
            state_q   <= S_FETCH;
            step_q    <= STEP_ZERO;
            retired_q <= retired_q + CNT_W'(1);
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        default: begin
          state_q <= S_HALTED;
        end
      endcase
    end
  end

  // Control word selection; stall and the halt step blank the word so no
  // consumer sees a partial operation.
  always_comb begin
    ctrl_out = '0;
    if (!stall) begin
      case (state_q)
        S_FETCH: ctrl_out = (step_q == STEP_ZERO) ? FETCH_CTRL_0 : FETCH_CTRL_1;
        S_EXEC: begin
          if (!halt_step) begin
            ctrl_out = ucode_word[CTRL_W-1:0];
          end
        end
        default: ctrl_out = '0;
      endcase
    end
  end

  assign instr_done = last_step && !stall;
  assign halted     = (state_q == S_HALTED);
  assign step       = step_q;
  assign retired    = retired_q;
  assign ucode_addr = {opcode, step_q};

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: a table of per-cycle
// vectors is applied through a scoreboard queue, followed by hand-written
// sequences for halt, async reset and retired-counter wrap.

module tb_cpu_control_sequencer;

  localparam logic [14:0] F0 = 15'h1A2B;
  localparam logic [14:0] F1 = 15'h2C3D;

  typedef struct {
    logic        stall;
    logic [3:0]  opcode;
    logic [2:0]  step;
    logic [14:0] ctrl;
    logic        done;
    logic        halted;
    logic [3:0]  retired;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'h2;
  logic        stall = 1'b0;
  logic [6:0]  ucode_addr;
  logic [15:0] ucode_word;
  logic [14:0] ctrl_out;
  logic [2:0]  step;
  logic        halted;
  logic        instr_done;
  logic [3:0]  retired;

  int total = 0;
  int bad = 0;
  vec_t table_q[$];
  vec_t exp_q[$];

  cpu_control_sequencer #(
    .OPCODE_W(4), .CTRL_W(15), .MAX_STEPS(8), .STEP_W(3),
    .FETCH_CTRL_0(F0), .FETCH_CTRL_1(F1), .HALT_OPCODE(4'hF), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall),
    .ucode_addr(ucode_addr), .ucode_word(ucode_word), .ctrl_out(ctrl_out),
    .step(step), .halted(halted), .instr_done(instr_done), .retired(retired)
  );

  always #5 clk = ~clk;

  // ROM control word: opcode and step embedded plus an inverted copy so
  // every address gives a distinct, nonzero word.
  function automatic logic [14:0] rc(input int op, input int st);
    logic [3:0] o;
    logic [2:0] s;
    o = 4'(op);
    s = 3'(st);
    return {o, s, ~{o, s, 1'b1}};
  endfunction

  // End flag: op1 ends at step 2, op2 at step 4, op3 never, others at 3.
  function automatic logic [15:0] rom_word(input logic [6:0] a);
    logic e;
    case (a[6:3])
      4'h1:    e = (a[2:0] == 3'd2);
      4'h2:    e = (a[2:0] == 3'd4);
      4'h3:    e = 1'b0;
      default: e = (a[2:0] == 3'd3);
    endcase
    return {e, rc(int'(a[6:3]), int'(a[2:0]))};
  endfunction

  assign ucode_word = rom_word(ucode_addr);

  function automatic void add(input int st, input int op, input int sp,
                              input logic [14:0] c, input int d, input int h,
                              input int r);
    vec_t v;
    v.stall = 1'(st);
    v.opcode = 4'(op);
    v.step = 3'(sp);
    v.ctrl = c;
    v.done = 1'(d);
    v.halted = 1'(h);
    v.retired = 4'(r);
    table_q.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    stall = v.stall;
    opcode = v.opcode;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("step", 32'(step), 32'(e.step));
      chk("ctrl_out", 32'(ctrl_out), 32'(e.ctrl));
      chk("instr_done", 32'(instr_done), 32'(e.done));
      chk("halted", 32'(halted), 32'(e.halted));
      chk("retired", 32'(retired), 32'(e.retired));
      chk("ucode_addr", 32'(ucode_addr), 32'({e.opcode, e.step}));
    end
  endtask

  task automatic runTable();
    while (table_q.size() > 0) begin
      applyStimulus(table_q.pop_front());
      checkOutput();
    end
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_ctrl"}, 32'(ctrl_out), 32'd0);
    chk({tag, "_done"}, 32'(instr_done), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
  endtask

  initial begin
    // Reset held: outputs at reset values.
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Fetch, ROM-terminated op2, forced-end op3, stalls, halt.
    add(0, 2, 0, 15'h0, 0, 0, 0);
    add(0, 2, 0, F0, 0, 0, 0);
    add(0, 2, 1, F1, 0, 0, 0);
    add(0, 2, 2, rc(2, 2), 0, 0, 0);
    add(0, 2, 3, rc(2, 3), 0, 0, 0);
    add(0, 2, 4, rc(2, 4), 1, 0, 0);
    add(0, 2, 0, F0, 0, 0, 1);
    add(0, 3, 1, F1, 0, 0, 1);
    for (int s = 2; s < 7; s++) add(0, 3, s, rc(3, s), 0, 0, 1);
    add(0, 3, 7, rc(3, 7), 1, 0, 1);
    add(0, 2, 0, F0, 0, 0, 2);
    add(0, 2, 1, F1, 0, 0, 2);
    add(0, 2, 2, rc(2, 2), 0, 0, 2);
    for (int i = 0; i < 3; i++) add(1, 2, 3, 15'h0, 0, 0, 2);
    add(0, 2, 3, rc(2, 3), 0, 0, 2);
    add(0, 2, 4, rc(2, 4), 1, 0, 2);
    add(0, 2, 0, F0, 0, 0, 3);
    add(0, 2, 1, F1, 0, 0, 3);
    add(0, 2, 2, rc(2, 2), 0, 0, 3);
    add(0, 2, 3, rc(2, 3), 0, 0, 3);
    add(1, 2, 4, 15'h0, 0, 0, 3);
    add(1, 2, 4, 15'h0, 0, 0, 3);
    add(0, 2, 4, rc(2, 4), 1, 0, 3);
    add(1, 2, 0, 15'h0, 0, 0, 4);
    add(0, 2, 0, F0, 0, 0, 4);
    add(0, 15, 1, F1, 0, 0, 4);
    add(0, 15, 2, 15'h0, 0, 0, 4);
    for (int i = 0; i < 20; i++) add(i % 2, 15, 2, 15'h0, 0, 1, 4);
    runTable();

    // Async reset out of HALTED, no clock edge in between.
    #1 rst_n = 1'b0;
    #1;
    checkResetValues("halt_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Sixteen short instructions wrap the 4-bit retired counter.
    add(0, 1, 0, 15'h0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      add(0, 1, 0, F0, 0, 0, i % 16);
      add(0, 1, 1, F1, 0, 0, i % 16);
      add(0, 1, 2, rc(1, 2), 1, 0, i % 16);
    end
    add(0, 2, 0, F0, 0, 0, 1);
    add(0, 2, 1, F1, 0, 0, 1);
    add(0, 2, 2, rc(2, 2), 0, 0, 1);
    add(0, 2, 3, rc(2, 3), 0, 0, 1);
    runTable();

    // Reset mid-instruction at step 3, then restart from IDLE/FETCH.
    #1 rst_n = 1'b0;
    #1;
    checkResetValues("mid_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    add(0, 2, 0, 15'h0, 0, 0, 0);
    add(0, 2, 0, F0, 0, 0, 0);
    add(0, 2, 1, F1, 0, 0, 0);
    runTable();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
